// File: rtl/data_bus_if.sv
// CPU data-bus and console-transmit signal bundle for data_bus_responder.
// master = CPU/board side, slave = responder.
interface data_bus_if;
  // CPU data port: word address, store data/strobe, combinational load data.
  logic [13:0] addr;
  logic [31:0] wrData;
  logic        wrEn;
  logic [31:0] rdData;

  // Board peripherals.
  logic [7:0]  leds;

  // Console transmit handshake: a byte transfers at a rising edge where
  // txValid=1 and txReady=1. While txValid=1 and txReady=0, txData holds
  // its value, and txValid never drops without a transfer (except by reset).
  logic [7:0]  txData;
  logic        txValid;
  logic        txReady;

  modport master (
    output addr, wrData, wrEn, txReady,
    input  rdData, leds, txData, txValid
  );

  modport slave (
    input  addr, wrData, wrEn, txReady,
    output rdData, leds, txData, txValid
  );
endinterface

// File: rtl/data_bus_responder.sv
// Word-addressed data-bus responder: data RAM plus an I/O page holding LEDs,
// a free-running cycle counter, a console TX FIFO and a status register.
module data_bus_responder #(
  parameter int RAM_DEPTH  = 4096,
  parameter int FIFO_DEPTH = 16
) (
  input  logic      clk,
  input  logic      nRst,
  data_bus_if.slave bus
);

  localparam logic [13:0] LED_ADDR  = 14'h3FF0;
  localparam logic [13:0] CNT_ADDR  = 14'h3FF1;
  localparam logic [13:0] FIFO_ADDR = 14'h3FF2;
  localparam logic [13:0] STAT_ADDR = 14'h3FF3;

  localparam int RAM_AW  = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam int FIFO_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = FIFO_AW + 1;

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic              hit_ram;
  logic              hit_led;
  logic              hit_cnt;
  logic              hit_fifo;
  logic              hit_stat;
  logic              hit_none;
  logic              we;
  logic [RAM_AW-1:0] ram_idx;

  assign hit_ram  = ({18'd0, bus.addr} < 32'(RAM_DEPTH));
  assign hit_led  = (bus.addr == LED_ADDR);
  assign hit_cnt  = (bus.addr == CNT_ADDR);
  assign hit_fifo = (bus.addr == FIFO_ADDR);
  assign hit_stat = (bus.addr == STAT_ADDR);
  assign hit_none = !(hit_ram || hit_led || hit_cnt || hit_fifo || hit_stat);
  assign ram_idx  = bus.addr[RAM_AW-1:0];

  // A store coinciding with reset is dropped everywhere, including RAM.
  assign we = bus.wrEn && !nRst;

  // ---------------------------------------------------------------------
  // Data RAM: synchronous write, asynchronous read, contents not reset
  // ---------------------------------------------------------------------
  logic [31:0] ram [RAM_DEPTH];
  logic [31:0] ram_rd;

  always_ff @(posedge clk) begin
    if (we && hit_ram) begin
      ram[ram_idx] <= bus.wrData;
    end
  end

  assign ram_rd = ram[ram_idx];

  // ---------------------------------------------------------------------
  // LED register and cycle counter
  // ---------------------------------------------------------------------
  logic [7:0]  leds_q;
  logic [31:0] cycle_cnt;

  always_ff @(posedge clk) begin
    if (nRst) begin
      leds_q <= 8'h00;
    end else if (we && hit_led) begin
      leds_q <= bus.wrData[7:0];
    end
  end

  // A CPU write replaces that cycle's increment.
  always_ff @(posedge clk) begin
    if (nRst) begin
      cycle_cnt <= 32'h0;
    end else if (we && hit_cnt) begin
      cycle_cnt <= bus.wrData;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Console TX FIFO
  // ---------------------------------------------------------------------
  logic [7:0]         fifo_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               full;
  logic               empty;
  logic               pop;
  logic               push_req;
  logic               push_ok;

  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign pop      = !empty && bus.txReady;
  assign push_req = we && hit_fifo;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok  = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= bus.wrData[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (nRst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign bus.txData  = fifo_mem[rd_ptr];
  assign bus.txValid = !empty;

  // ---------------------------------------------------------------------
  // Sticky error flags, cleared by writing 1s to the status register
  // ---------------------------------------------------------------------
  logic ovf;
  logic bus_err;

  always_ff @(posedge clk) begin
    if (nRst) begin
      ovf <= 1'b0;
    end else if (push_req && !push_ok) begin
      ovf <= 1'b1;
    end else if (we && hit_stat && bus.wrData[2]) begin
      ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (nRst) begin
      bus_err <= 1'b0;
    end else if (we && hit_none) begin
      bus_err <= 1'b1;
    end else if (we && hit_stat && bus.wrData[3]) begin
      bus_err <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Load data: combinational from addr and current state, no side effects
  // ---------------------------------------------------------------------
  logic [7:0]  count8;
  logic [31:0] status;
  logic [31:0] rd_mux;

  always_comb begin
    count8             = '0;
    count8[CNT_W-1:0]  = count;
  end

  assign status = {16'h0, count8, 4'h0, bus_err, ovf, full, empty};

  always_comb begin
    rd_mux = 32'h0;
    if (hit_ram) begin
      rd_mux = ram_rd;
    end else if (hit_led) begin
      rd_mux = {24'h0, leds_q};
    end else if (hit_cnt) begin
      rd_mux = cycle_cnt;
    end else if (hit_stat) begin
      rd_mux = status;
    end
  end

  assign bus.rdData = rd_mux;
  assign bus.leds   = leds_q;

endmodule

// File: tb/tb_data_bus_responder.sv
// Self-checking bench for data_bus_responder: directed scenarios plus
// randomized traffic checked against a queue/array model of the memory map.
module tb_data_bus_responder;

  localparam logic [13:0] LED_A  = 14'h3FF0;
  localparam logic [13:0] CNT_A  = 14'h3FF1;
  localparam logic [13:0] FIFO_A = 14'h3FF2;
  localparam logic [13:0] STAT_A = 14'h3FF3;

  logic clk = 1'b0;
  logic nRst;

  data_bus_if bus ();

  data_bus_responder #(
    .RAM_DEPTH  (4096),
    .FIFO_DEPTH (16)
  ) dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model
  logic [7:0]  exp_q[$];
  logic [31:0] ram_model [int];
  logic        model_ovf  = 1'b0;
  logic        model_berr = 1'b0;
  logic [7:0]  model_leds = 8'h00;

  function automatic logic [31:0] status_model();
    logic [7:0] c;
    c = 8'(exp_q.size());
    return {16'h0, c, 4'h0, model_berr, model_ovf,
            (exp_q.size() == 16), (exp_q.size() == 0)};
  endfunction

  // Driver tasks: inputs change 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.addr   = 14'h3FFF;
    bus.wrData = 32'h0;
    bus.wrEn   = 1'b0;
  endtask

  task automatic bus_write(input logic [13:0] a, input logic [31:0] d);
    bus.addr   = a;
    bus.wrData = d;
    bus.wrEn   = 1'b1;
    tick();
    bus.wrEn   = 1'b0;
  endtask

  task automatic bus_read(input logic [13:0] a, output logic [31:0] d);
    bus.addr = a;
    bus.wrEn = 1'b0;
    #1;
    d = bus.rdData;
  endtask

  // Push with txReady=0: model queue accepts only while not full.
  task automatic push_byte(input logic [7:0] b);
    if (exp_q.size() < 16) exp_q.push_back(b);
    else                   model_ovf = 1'b1;
    bus_write(FIFO_A, {24'hABCDE0, b});
  endtask

  task automatic reset_model();
    exp_q.delete();
    model_ovf  = 1'b0;
    model_berr = 1'b0;
    model_leds = 8'h00;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    nRst = 1'b1;
    bus.txReady = 1'b0;
    drive_idle();
    tick();
    bus_write(LED_A, 32'hFF);   // coincides with reset: must be ignored
    nRst = 1'b0;
    reset_model();
    tests_run++;
    if (bus.leds !== 8'h00) begin
      tests_failed++; $display("FAIL reset_leds got %h want 00", bus.leds);
    end
    tests_run++;
    if (bus.txValid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_txvalid got %b want 0", bus.txValid);
    end
    bus_read(STAT_A, d);
    tests_run++;
    if (d !== 32'h1) begin
      tests_failed++; $display("FAIL reset_status got %h want 00000001", d);
    end
    bus_read(CNT_A, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++; $display("FAIL reset_counter got %h want 0", d);
    end
    repeat (3) tick();
    bus_read(CNT_A, d);
    tests_run++;
    if (d !== 32'h3) begin
      tests_failed++; $display("FAIL reset_counter_inc got %h want 3", d);
    end
  endtask

  task automatic test_ram();
    logic [31:0] d;
    logic [13:0] a;
    logic [31:0] v;
    bus_write(14'h0005, 32'hDEADBEEF);
    ram_model[5] = 32'hDEADBEEF;
    bus_read(14'h0005, d);
    tests_run++;
    if (d !== 32'hDEADBEEF) begin
      tests_failed++; $display("FAIL ram_raw got %h want deadbeef", d);
    end
    bus_write(14'd4095, 32'h0F0F1234);
    ram_model[4095] = 32'h0F0F1234;
    for (int i = 0; i < 20; i++) begin
      a = 14'($urandom_range(0, 4095));
      v = $urandom;
      bus_write(a, v);
      ram_model[int'(a)] = v;
    end
    drive_idle();
    foreach (ram_model[k]) begin
      bus_read(14'(k), d);
      tests_run++;
      if (d !== ram_model[k]) begin
        tests_failed++; $display("FAIL ram_rand addr %0d got %h want %h", k, d, ram_model[k]);
      end
      tick();
    end
  endtask

  task automatic test_led();
    logic [31:0] d;
    logic [31:0] v;
    bus_write(LED_A, 32'h000001A5);
    model_leds = 8'hA5;
    tests_run++;
    if (bus.leds !== 8'hA5) begin
      tests_failed++; $display("FAIL led_out got %h want a5", bus.leds);
    end
    bus_read(LED_A, d);
    tests_run++;
    if (d !== 32'h000000A5) begin
      tests_failed++; $display("FAIL led_read got %h want 000000a5", d);
    end
    for (int i = 0; i < 4; i++) begin
      v = $urandom;
      bus_write(LED_A, v);
      model_leds = v[7:0];
      bus_read(LED_A, d);
      tests_run++;
      if (d !== {24'h0, model_leds} || bus.leds !== model_leds) begin
        tests_failed++; $display("FAIL led_rand got %h/%h want %h", d, bus.leds, model_leds);
      end
    end
  endtask

  task automatic test_counter();
    logic [31:0] d;
    logic [31:0] d2;
    int k;
    bus_write(CNT_A, 32'h100);
    drive_idle();
    repeat (10) tick();
    bus_read(CNT_A, d);
    tests_run++;
    if (d !== 32'h10A) begin
      tests_failed++; $display("FAIL cnt_load got %h want 0000010a", d);
    end
    bus_write(CNT_A, 32'hFFFFFFFF);
    drive_idle();
    repeat (2) tick();
    bus_read(CNT_A, d);
    tests_run++;
    if (d !== 32'h1) begin
      tests_failed++; $display("FAIL cnt_wrap got %h want 00000001", d);
    end
    for (int i = 0; i < 3; i++) begin
      k = $urandom_range(1, 40);
      bus_read(CNT_A, d);
      repeat (k) tick();
      bus_read(CNT_A, d2);
      tests_run++;
      if (d2 - d !== 32'(k)) begin
        tests_failed++; $display("FAIL cnt_delta got %0d want %0d", d2 - d, k);
      end
    end
  endtask

  task automatic test_fifo_fill_drain();
    logic [31:0] d;
    logic [7:0]  e;
    bus.txReady = 1'b0;
    for (int i = 1; i <= 16; i++) push_byte(8'(i));
    bus_read(STAT_A, d);
    tests_run++;
    if (d !== 32'h00001002 || d !== status_model()) begin
      tests_failed++; $display("FAIL fifo_full_status got %h want 00001002", d);
    end
    push_byte(8'h11);
    bus_read(STAT_A, d);
    tests_run++;
    if (d !== 32'h00001006 || d !== status_model()) begin
      tests_failed++; $display("FAIL fifo_ovf_status got %h want 00001006", d);
    end
    drive_idle();
    bus.txReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      e = exp_q.pop_front();
      tests_run++;
      if (bus.txValid !== 1'b1 || bus.txData !== e) begin
        tests_failed++; $display("FAIL fifo_drain %0d got v=%b d=%h want v=1 d=%h", i, bus.txValid, bus.txData, e);
      end
      tick();
    end
    tests_run++;
    if (bus.txValid !== 1'b0) begin
      tests_failed++; $display("FAIL fifo_empty_after_drain got %b want 0", bus.txValid);
    end
    bus.txReady = 1'b0;
  endtask

  task automatic test_full_push_pop();
    logic [31:0] d;
    logic [7:0]  e;
    for (int i = 0; i < 16; i++) push_byte(8'($urandom));
    // Full FIFO: push and pop in the same cycle.
    tests_run++;
    if (bus.txData !== exp_q[0]) begin
      tests_failed++; $display("FAIL fpp_head got %h want %h", bus.txData, exp_q[0]);
    end
    void'(exp_q.pop_front());
    exp_q.push_back(8'h5A);
    bus.txReady = 1'b1;
    bus_write(FIFO_A, 32'h5A);
    bus.txReady = 1'b0;
    bus_read(STAT_A, d);
    tests_run++;
    if (d !== status_model()) begin
      tests_failed++; $display("FAIL fpp_status got %h want %h", d, status_model());
    end
    bus_write(STAT_A, 32'h4);
    model_ovf = 1'b0;
    bus_read(STAT_A, d);
    tests_run++;
    if (d[2] !== 1'b0 || d !== status_model()) begin
      tests_failed++; $display("FAIL ovf_clear got %h want %h", d, status_model());
    end
    drive_idle();
    bus.txReady = 1'b1;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      tests_run++;
      if (bus.txValid !== 1'b1 || bus.txData !== e) begin
        tests_failed++; $display("FAIL fpp_drain got v=%b d=%h want v=1 d=%h", bus.txValid, bus.txData, e);
      end
      tick();
    end
    bus.txReady = 1'b0;
  endtask

  task automatic test_bus_err();
    logic [31:0] d;
    bus_write(14'h0000, 32'h12345678);
    ram_model[0] = 32'h12345678;
    bus_write(14'h2000, 32'hCAFEF00D);
    model_berr = 1'b1;
    bus_read(STAT_A, d);
    tests_run++;
    if (d !== status_model() || d[3] !== 1'b1) begin
      tests_failed++; $display("FAIL berr_set got %h want %h", d, status_model());
    end
    bus_read(14'h2000, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++; $display("FAIL unmapped_read got %h want 0", d);
    end
    tick();
    bus_read(14'h0000, d);
    tests_run++;
    if (d !== ram_model[0]) begin
      tests_failed++; $display("FAIL berr_ram_intact got %h want %h", d, ram_model[0]);
    end
    bus_read(14'h3FF4, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++; $display("FAIL unmapped_3ff4 got %h want 0", d);
    end
    tick();
    bus_read(FIFO_A, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++; $display("FAIL fifo_reg_read got %h want 0", d);
    end
    bus_write(STAT_A, 32'h8);
    model_berr = 1'b0;
    bus_read(STAT_A, d);
    tests_run++;
    if (d !== status_model()) begin
      tests_failed++; $display("FAIL berr_clear got %h want %h", d, status_model());
    end
  endtask

  task automatic test_random_fifo();
    logic [31:0] d;
    logic        push;
    logic        ready;
    logic        popped;
    logic [7:0]  b;
    for (int i = 0; i < 300; i++) begin
      push  = ($urandom_range(0, 99) < 60);
      ready = ($urandom_range(0, 99) < 45);
      b     = 8'($urandom);
      tests_run++;
      if (bus.txValid !== (exp_q.size() != 0) ||
          (exp_q.size() != 0 && bus.txData !== exp_q[0])) begin
        tests_failed++;
        $display("FAIL rand_fifo cyc %0d got v=%b d=%h want size %0d", i, bus.txValid, bus.txData, exp_q.size());
      end
      popped = ready && (exp_q.size() != 0);
      if (popped) void'(exp_q.pop_front());
      if (push) begin
        if (exp_q.size() < 16) exp_q.push_back(b);
        else                   model_ovf = 1'b1;
      end
      bus.txReady = ready;
      bus.addr    = FIFO_A;
      bus.wrData  = {24'h0, b};
      bus.wrEn    = push;
      tick();
    end
    drive_idle();
    bus.txReady = 1'b0;
    bus_read(STAT_A, d);
    tests_run++;
    if (d !== status_model()) begin
      tests_failed++; $display("FAIL rand_fifo_status got %h want %h", d, status_model());
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    bus.txReady = 1'b0;
    // Leave exactly 5 bytes queued.
    while (exp_q.size() > 5) begin
      bus.txReady = 1'b1;
      void'(exp_q.pop_front());
      tick();
    end
    bus.txReady = 1'b0;
    while (exp_q.size() < 5) push_byte(8'($urandom));
    tests_run++;
    if (bus.txValid !== 1'b1) begin
      tests_failed++; $display("FAIL mid_queued got %b want 1", bus.txValid);
    end
    nRst = 1'b1;
    tick();
    nRst = 1'b0;
    reset_model();
    tests_run++;
    if (bus.txValid !== 1'b0) begin
      tests_failed++; $display("FAIL mid_reset_txvalid got %b want 0", bus.txValid);
    end
    bus_read(STAT_A, d);
    tests_run++;
    if (d !== 32'h1) begin
      tests_failed++; $display("FAIL mid_reset_status got %h want 00000001", d);
    end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_led();
    test_counter();
    test_fifo_fill_drain();
    test_full_push_pop();
    test_bus_err();
    test_random_fifo();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/data_bus_responder.md
# data_bus_responder

Word-addressed responder on the CPU data bus. Serves CPU LOAD/STORE accesses with on-chip data RAM plus a small memory-mapped I/O page: LED register, free-running cycle counter, console TX FIFO and status register. The FIFO drains to a byte-wide serial transmitter through a valid/ready handshake. Sits between the CPU data port and the board-level peripherals.

## Interface
- RAM_DEPTH, 4096: data RAM words, mapped at 0x0000..RAM_DEPTH-1; must be ≤ 0x3FF0.
- FIFO_DEPTH, 16: console FIFO entries; power of 2, 2..128.
- clk  in  1  clock; all state updates on rising edge.
- nRst  in  1  reset, synchronous, active-high.
- addr  in  14  word address; driven by the CPU's dataAddress.
- wrData  in  32  store data; driven by the CPU's dataOut.
- wrEn  in  1  store strobe; driven by the CPU's dataWrEn.
- rdData  out  32  load data; drives the CPU's dataIn.
- leds  out  8  LED register contents.
- txData  out  8  FIFO head byte.
- txValid  out  1  FIFO non-empty.
- txReady  in  1  transmitter accepts txData this cycle.

## Operation
- Memory map:
  - 0x0000..RAM_DEPTH-1: RAM, read/write.
  - 0x3FF0: LED register. Read returns {24'h0, leds}. Write stores wrData[7:0].
  - 0x3FF1: cycle counter, 32 bit. Read returns the current value. Write loads wrData.
  - 0x3FF2: FIFO push. Write pushes wrData[7:0]. Read returns 0.
  - 0x3FF3: status. Read returns {16'h0, count[7:0], 4'h0, busErr, ovf, full, empty}. Write: a 1 in bit 2 clears ovf; a 1 in bit 3 clears busErr; other bits ignored.
  - Any other address: read returns 0. A write is ignored and sets busErr (sticky).
- Reads are side-effect free; reading the status register does not clear any bit.
- rdData is combinational from addr and the current registered state: async RAM read and register mux. There is no read enable.
- A store is performed at the rising edge where wrEn=1, using addr and wrData as sampled at that edge.
- Cycle counter:
  - Increments by 1 every cycle, wrapping from 0xFFFFFFFF to 0.
  - A write in the same cycle wins: the counter takes wrData, with no increment that cycle.
- FIFO:
  - Circular buffer with read and write pointers and a count of width log2(FIFO_DEPTH)+1.
  - pop = txValid & txReady.
  - A push is accepted when count < FIFO_DEPTH, or when pop is asserted in the same cycle.
  - A rejected push sets ovf and leaves FIFO contents unchanged.
  - Simultaneous accepted push and pop leaves count unchanged and advances both pointers.
  - Pop when empty cannot occur, since txValid=0.
- txData = entry at the read pointer. txValid = (count != 0).

## Timing
- Reset (nRst=1 at an edge): leds=0, counter=0, FIFO pointers and count=0, ovf=0, busErr=0. So txValid=0 and status reads 0x0001 the cycle after reset.
- RAM contents are not reset. A RAM read before any write returns an undefined value.
- rdData reset value: follows addr. For example, 0 at unmapped addresses and 0x01 at status.
- Reset mid-operation: any queued bytes are discarded and txValid drops on the next cycle. A wrEn coinciding with reset is ignored.
- Load latency:
  - The CPU drives addr at edge N and samples dataIn at edge N+1.
  - rdData must therefore be valid within the cycle following addr change. There are zero wait states.
- Store to read-after-write at the same address: the value written at edge N is visible on rdData in cycle N+1.
- Counter read: returns the value present during the cycle. Two reads k cycles apart differ by k.
- FIFO handshake:
  - A byte pushed at edge N gives txValid=1 during cycle N+1 if the FIFO was empty.
  - txData must stay stable while txValid=1 and txReady=0.

## Test plan
- Reset with nRst=1 for 2 cycles -> leds=0, txValid=0, read 0x3FF3 = 0x00000001, read 0x3FF1 small and increasing.
- Write 0xDEADBEEF to 0x0005, then read 0x0005 next cycle -> rdData=0xDEADBEEF. Write 0x1A5 to 0x3FF0 -> leds=0xA5, read returns 0x000000A5.
- Write 0x100 to 0x3FF1, idle 10 cycles, read -> 0x10A. Write 0xFFFFFFFF, read 2 cycles later -> 0x00000001 (wrap).
- txReady=0, push bytes 0x01..0x10 (16 pushes) -> status = 0x00001002 (count 16, full). 17th push (0x11) -> ovf=1, status 0x00001006. Then txReady=1 -> bytes 0x01..0x10 emerge in order, one per cycle, and txValid falls after the 16th.
- FIFO full with push and pop in the same cycle -> push accepted, count stays 16, ovf unchanged. Write 0x4 to 0x3FF3 clears ovf, reads back with bit 2=0.
- Write to 0x2000 -> busErr=1 (status bit 3), RAM unchanged. Read 0x2000 -> 0. Assert nRst with 5 bytes queued -> txValid=0 next cycle, status 0x00000001.
